// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Forward-select encodings match the EX operand mux inputs in the datapath.
package pipe_pkg;

    localparam int unsigned PIPE_RADDR_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                    valid;
        logic                    wr_en;
        logic [PIPE_RADDR_W-1:0] wr_addr;
        logic                    mem_read;
    } stage_t;

    // A stage can source a forward when it really writes a non-zero register;
    // load data only exists once the stage is past MEM.
    function automatic logic fwd_src_ok(input stage_t s, input logic allow_load);
        return s.valid & s.wr_en & (s.wr_addr != '0) & (allow_load | ~s.mem_read);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Single-operand EX forwarding select: youngest producer (MEM) wins over WB.
module pipe_fwd_sel
    import pipe_pkg::*;
(
    input  logic                    uses,
    input  logic [PIPE_RADDR_W-1:0] src,
    input  stage_t                  mem_stage,
    input  stage_t                  wb_stage,
    output logic [1:0]              sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = fwd_src_ok(mem_stage, 1'b0) & (mem_stage.wr_addr == src);
        wb_hit  = fwd_src_ok(wb_stage, 1'b1) & (wb_stage.wr_addr == src);
        sel     = FWD_RF;
        if (uses) begin
            if (mem_hit) begin
                sel = FWD_MEM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: keeps a shadow of the
// EX/MEM/WB destinations and drives stall, bubble, flush and bypass selects.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned RADDR_W      = PIPE_RADDR_W,
    parameter int unsigned MULTI_EX_LAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_wr_en,
    input  logic [RADDR_W-1:0] id_wr_addr,
    input  logic               id_mem_read,
    input  logic               id_multi,
    input  logic               ex_redirect,
    output logic               stall_if,
    output logic               stall_id,
    output logic               stall_ex,
    output logic               bubble_ex,
    output logic               bubble_mem,
    output logic               flush_id,
    output logic [1:0]         fwd_a_sel,
    output logic [1:0]         fwd_b_sel,
    output logic               fwd_id_a,
    output logic               fwd_id_b,
    output logic               ex_busy
);

    localparam int unsigned CNT_W = (MULTI_EX_LAT > 1) ? $clog2(MULTI_EX_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_EX_LAT - 1);

    stage_t                  ex_q;
    stage_t                  mem_q;
    stage_t                  wb_q;
    stage_t                  ex_next;
    logic [PIPE_RADDR_W-1:0] ex_rs_q;
    logic [PIPE_RADDR_W-1:0] ex_rt_q;
    logic                    ex_uses_rs_q;
    logic                    ex_uses_rt_q;
    logic [CNT_W-1:0]        busy_cnt_q;

    logic [PIPE_RADDR_W-1:0] id_rs_w;
    logic [PIPE_RADDR_W-1:0] id_rt_w;
    logic [PIPE_RADDR_W-1:0] id_wr_addr_w;
    logic                    busy;
    logic                    redirect;
    logic                    id_dep_on_ex;
    logic                    load_use;
    logic                    ex_enter_valid;
    logic                    wb_bypass_ok;

    assign id_rs_w      = PIPE_RADDR_W'(id_rs);
    assign id_rt_w      = PIPE_RADDR_W'(id_rt);
    assign id_wr_addr_w = PIPE_RADDR_W'(id_wr_addr);

    always_comb begin
        busy         = (busy_cnt_q != '0);
        redirect     = ex_q.valid & ex_redirect;
        id_dep_on_ex = (id_uses_rs & (id_rs_w == ex_q.wr_addr))
                     | (id_uses_rt & (id_rt_w == ex_q.wr_addr));
        // Busy masks load-use; it re-evaluates once the multi-cycle op drains.
        load_use     = ~busy & fwd_src_ok(ex_q, 1'b1) & ex_q.mem_read
                     & id_valid & id_dep_on_ex;

        stall_if   = busy | (load_use & ~redirect);
        stall_id   = busy | (load_use & ~redirect);
        stall_ex   = busy;
        bubble_ex  = load_use | redirect;
        bubble_mem = busy;
        flush_id   = redirect;
        ex_busy    = busy;

        ex_enter_valid = id_valid & ~bubble_ex & ~redirect;
        wb_bypass_ok   = fwd_src_ok(wb_q, 1'b1);
        fwd_id_a       = wb_bypass_ok & (wb_q.wr_addr == id_rs_w);
        fwd_id_b       = wb_bypass_ok & (wb_q.wr_addr == id_rt_w);
    end

    always_comb begin
        ex_next          = '0;
        ex_next.valid    = ex_enter_valid;
        ex_next.wr_en    = id_wr_en;
        ex_next.wr_addr  = id_wr_addr_w;
        ex_next.mem_read = id_mem_read;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_uses_rs_q <= 1'b0;
            ex_uses_rt_q <= 1'b0;
            busy_cnt_q   <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= bubble_mem ? '0 : ex_q;
            if (!busy) begin
                ex_q         <= ex_next;
                ex_rs_q      <= id_rs_w;
                ex_rt_q      <= id_rt_w;
                // A bubble reads no sources, so it never requests a forward.
                ex_uses_rs_q <= id_uses_rs & ex_enter_valid;
                ex_uses_rt_q <= id_uses_rt & ex_enter_valid;
                busy_cnt_q   <= (ex_enter_valid & id_multi) ? CNT_LOAD : '0;
            end else begin
                busy_cnt_q <= busy_cnt_q - 1'b1;
            end
        end
    end

    pipe_fwd_sel u_fwd_a (
        .uses      (ex_uses_rs_q),
        .src       (ex_rs_q),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (fwd_a_sel)
    );

    pipe_fwd_sel u_fwd_b (
        .uses      (ex_uses_rt_q),
        .src       (ex_rt_q),
        .mem_stage (mem_q),
        .wb_stage  (wb_q),
        .sel       (fwd_b_sel)
    );

endmodule
